// File: rtl/conv_encoder.sv
// Rate-1/2, K=4 convolutional encoder (g0=1011, g1=1111) with framed input and registered output.
// Define TAIL_FLUSH_EN to append three zero-input tail symbols that return the register to zero.
module conv_encoder #(
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       Dx,
  input  logic       den,
  output logic       in_rdy,
  output logic [1:0] Rx,
  output logic       oen,
  output logic       seqrdy,
  output logic       frame_done
);

  typedef enum logic [1:0] {StIdle, StEnc, StTail} state_e;

  localparam logic [7:0] LastCnt = 8'(FRAME_LEN - 1);
`ifdef TAIL_FLUSH_EN
  localparam state_e DoneState = StTail;
`else
  localparam state_e DoneState = StIdle;
`endif

  state_e     state_q, state_d;
  logic [2:0] s_q, s_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] tail_q, tail_d;
  logic [1:0] rx_q, rx_d;
  logic       oen_q, oen_d;
  logic       seq_q, seq_d;
  logic       done_q, done_d;
  logic       accept;
  logic       last_bit;

  function automatic logic [1:0] symbol(input logic d, input logic [2:0] s);
    return {d ^ s[1] ^ s[2], d ^ s[0] ^ s[1] ^ s[2]};
  endfunction

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StEnc: begin
        if (accept) begin
          state_d = last_bit ? DoneState : StEnc;
        end
      end
      StTail: begin
        if (tail_q == 2'd2) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic; in_rdy is gated by reset so it reads 0 while reset is held
  always_comb begin
    in_rdy     = ~reset & (state_q != StTail);
    Rx         = rx_q;
    oen        = oen_q;
    seqrdy     = seq_q;
    frame_done = done_q;
  end

  assign accept   = den & in_rdy;
  assign last_bit = (cnt_q == LastCnt);

  // Datapath next-state: shift register, bit counter, tail counter, registered symbol
  always_comb begin
    s_d    = s_q;
    cnt_d  = cnt_q;
    tail_d = tail_q;
    rx_d   = 2'b00;
    oen_d  = 1'b0;
    seq_d  = 1'b0;
    done_d = 1'b0;
    if (accept) begin
      rx_d  = symbol(Dx, s_q);
      oen_d = 1'b1;
      seq_d = (state_q == StIdle);
      s_d   = {s_q[1:0], Dx};
      if (last_bit) begin
        cnt_d = 8'd0;
`ifndef TAIL_FLUSH_EN
        s_d    = 3'b000;
        done_d = 1'b1;
`endif
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else if (state_q == StTail) begin
      rx_d  = symbol(1'b0, s_q);
      oen_d = 1'b1;
      s_d   = {s_q[1:0], 1'b0};
      if (tail_q == 2'd2) begin
        tail_d = 2'd0;
        done_d = 1'b1;
      end else begin
        tail_d = tail_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_q    <= 3'b000;
      cnt_q  <= 8'd0;
      tail_q <= 2'd0;
      rx_q   <= 2'b00;
      oen_q  <= 1'b0;
      seq_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cnt_q  <= cnt_d;
      tail_q <= tail_d;
      rx_q   <= rx_d;
      oen_q  <= oen_d;
      seq_q  <= seq_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Scoreboard bench for conv_encoder (FRAME_LEN=4); follows TAIL_FLUSH_EN if defined at compile time.
module tb_conv_encoder;

  localparam int FL = 4;
`ifdef TAIL_FLUSH_EN
  localparam bit Flush = 1'b1;
`else
  localparam bit Flush = 1'b0;
`endif

  typedef struct packed {
    logic       oen;
    logic [1:0] rx;
    logic       seq;
    logic       fd;
  } exp_t;

  logic       clock;
  logic       reset;
  logic       Dx;
  logic       den;
  logic       in_rdy;
  logic [1:0] Rx;
  logic       oen;
  logic       seqrdy;
  logic       frame_done;

  int n_checks;
  int n_fail;

  exp_t       sb[$];
  logic [3:0] obs_log[$];
  bit         capture;

  // Reference model state: 0=IDLE, 1=ENC, 2=TAIL
  int         m_state;
  int         m_cnt;
  int         m_tail;
  logic [2:0] m_s;

  conv_encoder #(.FRAME_LEN(FL)) dut (
    .clock      (clock),
    .reset      (reset),
    .Dx         (Dx),
    .den        (den),
    .in_rdy     (in_rdy),
    .Rx         (Rx),
    .oen        (oen),
    .seqrdy     (seqrdy),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_tail  = 0;
    m_s     = 3'b000;
    sb.delete();
  endtask

  // One clock of stimulus: predict, push, let the edge happen, pop and compare
  task automatic step(input logic d, input logic v);
    exp_t e;
    logic m_rdy;
    logic acc;
    @(negedge clock);
    Dx  = d;
    den = v;
    m_rdy = (m_state != 2);
    check_eq("in_rdy", in_rdy, m_rdy);
    acc = v && m_rdy;
    e   = '0;
    if (acc) begin
      e.oen = 1'b1;
      e.rx  = {d ^ m_s[1] ^ m_s[2], d ^ m_s[0] ^ m_s[1] ^ m_s[2]};
      e.seq = (m_state == 0);
      m_s   = {m_s[1:0], d};
      if (m_cnt == FL - 1) begin
        m_cnt = 0;
        if (Flush) begin
          m_state = 2;
        end else begin
          m_state = 0;
          m_s     = 3'b000;
          e.fd    = 1'b1;
        end
      end else begin
        m_cnt++;
        m_state = 1;
      end
    end else if (m_state == 2) begin
      e.oen = 1'b1;
      e.rx  = {m_s[1] ^ m_s[2], m_s[0] ^ m_s[1] ^ m_s[2]};
      m_s   = {m_s[1:0], 1'b0};
      if (m_tail == 2) begin
        e.fd    = 1'b1;
        m_state = 0;
        m_tail  = 0;
      end else begin
        m_tail++;
      end
    end
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check_eq("oen", oen, e.oen);
    check_eq("Rx", Rx, e.rx);
    check_eq("seqrdy", seqrdy, e.seq);
    check_eq("frame_done", frame_done, e.fd);
    if (capture && oen) obs_log.push_back({Rx, seqrdy, frame_done});
  endtask

  task automatic drain();
    repeat (4) step(1'b0, 1'b0);
  endtask

  // Impulse response against fixed constants, independent of the model
  task automatic check_impulse();
    logic [1:0] exp_rx[7];
    int n;
    exp_rx = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
    n = Flush ? 7 : 4;
    check_eq("imp_len", 8'(obs_log.size()), 8'(n));
    for (int i = 0; i < n && i < obs_log.size(); i++) begin
      check_eq("imp_rx", obs_log[i][3:2], exp_rx[i]);
      check_eq("imp_seq", obs_log[i][1], (i == 0));
      check_eq("imp_done", obs_log[i][0], (i == n - 1));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    capture  = 1'b0;
    clock    = 1'b0;
    reset    = 1'b1;
    Dx       = 1'b0;
    den      = 1'b0;
    model_reset();

    repeat (2) @(negedge clock);
    check_eq("rst_rx", Rx, 2'b00);
    check_eq("rst_oen", oen, 1'b0);
    check_eq("rst_seq", seqrdy, 1'b0);
    check_eq("rst_done", frame_done, 1'b0);
    check_eq("rst_rdy", in_rdy, 1'b0);
    reset = 1'b0;
    #1;
    check_eq("rdy_after_rst", in_rdy, 1'b1);

    // Impulse
    obs_log.delete();
    capture = 1'b1;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    drain();
    capture = 1'b0;
    check_impulse();

    // All-zero frame
    repeat (FL) step(1'b0, 1'b1);
    drain();

    // Gapped input inside a frame
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    drain();

    // Back-to-back frames
    repeat (2 * FL) step(1'b1, 1'b1);
    drain();

    // den held high through the tail
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b1);
    drain();
    drain();

    // Reset mid-frame, then impulse must reproduce exactly
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    @(negedge clock);
    den   = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("midrst_oen", oen, 1'b0);
    check_eq("midrst_rx", Rx, 2'b00);
    check_eq("midrst_done", frame_done, 1'b0);
    check_eq("midrst_rdy", in_rdy, 1'b0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    obs_log.delete();
    capture = 1'b1;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    drain();
    capture = 1'b0;
    check_impulse();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
